ram_bus_controller: RTL and testbench
=====================================

Name: ram_bus_controller

Overview:
Sequencer that sits directly upstream of the team's bidirectional-bus RAM (CS_ active-low, WS active-high, OE active-high, shared DATA bus). It accepts read/write requests on a valid/ready handshake and generates cycle-correct CS_/WS/OE/ADDR. It owns the controller side of the tri-state DATA bus and inserts a turnaround cycle after reads. Read data returns on a one-cycle RD_VALID pulse.

Parameters:
WIDTH, 8, data width in bits; must equal the RAM's WIDTH
DEPTH, 32, number of RAM words; address width is $clog2(DEPTH)

Ports:
CLK  input  1  system clock, rising-edge
RST  input  1  asynchronous reset, active-high
REQ_VALID  input  1  request present
REQ_READY  output  1  controller can accept a request this cycle
REQ_WRITE  input  1  1 = write, 0 = read
REQ_ADDR  input  $clog2(DEPTH)  request address
REQ_WDATA  input  WIDTH  write data
RD_VALID  output  1  one-cycle pulse; RD_DATA holds valid read data
RD_DATA  output  WIDTH  captured read data
CS_  output  1  RAM chip select, active low
WS  output  1  RAM write strobe, active high
OE  output  1  RAM output enable, active high
ADDR  output  $clog2(DEPTH)  RAM address
DATA  inout  WIDTH  shared bidirectional data bus to the RAM

Behaviour:
- Clocking and reset: one clock (CLK). RST is asynchronous and active-high.
- Reset values: state IDLE, CS_=1, WS=0, OE=0, ADDR=0, RD_VALID=0, RD_DATA=0, DATA released (all z).
- REQ_READY is forced to 0 while RST is high.
- CS_, WS, OE and ADDR are all registered outputs; none comes from combinational logic.
- Handshake:
  - A request is accepted on the rising edge where REQ_VALID && REQ_READY.
  - REQ_WRITE, REQ_ADDR and REQ_WDATA are latched internally at that edge.
  - REQ_READY = 1 only in IDLE.
- States:
  - IDLE: CS_=1, WS=0, OE=0, DATA released. On accept, go to WRITE or READ per REQ_WRITE.
  - WRITE (1 cycle): CS_=0, WS=1, OE=0, ADDR=latched address. DATA is driven with latched write data. The RAM stores it at the edge ending this cycle. Next state is IDLE.
  - READ (1 cycle): CS_=0, OE=1, WS=0, ADDR=latched address. The controller releases DATA and the RAM drives it combinationally. DATA is sampled into RD_DATA at the edge ending this cycle. Next state is TURN.
  - TURN (1 cycle): CS_=1, OE=0, WS=0, DATA released. RD_VALID=1 this cycle. Next state is IDLE.
- Latency (accept at edge E0):
  - Write strobe occupies the cycle after E0.
  - Read data is presented with RD_VALID=1 in the second cycle after E0.
  - RD_DATA holds its value until the next read capture.
- Throughput: one write per 2 cycles, one read per 3 cycles.
- Bus-contention rule: the controller drives DATA if and only if state == WRITE. OE and the controller's DATA drive are never 1 in the same cycle.
- WS is never 1 while OE=1 or CS_=1.
- REQ_VALID asserted outside IDLE is ignored; it is not accepted and not queued.
- Reset mid-operation: all outputs go to their reset values immediately, asynchronously. An in-flight write may be lost. An in-flight read produces no RD_VALID.
- Address range: every REQ_ADDR value is legal; there is no range check.

Decomposition:
- Package ram_ctrl_pkg contains:
  - typedef enum logic [1:0] ctrl_state_t {IDLE, WRITE, READ, TURN}
  - localparam TURN_CYCLES = 1
- Sub-module bus_tristate (parameter WIDTH; ports EN, DIN, DOUT, PAD): owns the DATA drive/release and the combinational sample path. The controller instantiates one.

Test Plan:
1. Reset: assert RST mid-cycle with REQ_VALID=1 -> immediately CS_=1, WS=0, OE=0, DATA=z, REQ_READY=0, RD_VALID=0. After release, REQ_READY=1 on the next edge.
2. Single write then read (WIDTH=8, DEPTH=32): write ADDR=5, WDATA=8'hA5, then read ADDR=5 -> one WS=1 cycle with CS_=0, OE=0, DATA=8'hA5. RD_VALID pulses 2 cycles after read accept with RD_DATA=8'hA5.
3. Back-to-back read then write: read ADDR=3, then write ADDR=3 with 8'h3C held valid -> TURN cycle with DATA=z separates OE=1 from controller drive. Write is accepted only after TURN. A later read of ADDR=3 returns 8'h3C.
4. Held REQ_VALID: hold REQ_VALID=1 for 6 cycles with writes to ADDR 0..2 -> exactly 3 accepts, one every 2 cycles, no WS pulse without a matching accept.
5. Boundary addresses: write 8'h01 to ADDR=0 and 8'hFF to ADDR=31, then read both -> 8'h01 and 8'hFF returned in order, each with a single RD_VALID pulse.
6. Reset during READ: assert RST in the READ cycle -> no RD_VALID pulse, RD_DATA=0, OE=0 at once. Next request is serviced normally.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared types for the RAM bus sequencer.
package ram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    TURN  = 2'd3
  } ctrl_state_t;

  // Dead cycles inserted after a read before the controller may drive DATA again.
  localparam int TURN_CYCLES = 1;

endpackage

// File: rtl/bus_tristate.sv
// Controller side of the shared DATA bus: drive when enabled, always sample.
module bus_tristate #(
  parameter int WIDTH = 8
) (
  input  logic             EN,
  input  logic [WIDTH-1:0] DIN,
  output logic [WIDTH-1:0] DOUT,
  inout  wire  [WIDTH-1:0] PAD
);

  // Release the pad completely when not enabled so the RAM can drive it.
  assign PAD  = EN ? DIN : {WIDTH{1'bz}};
  // Sample path is purely combinational; the capture flop lives in the controller.
  assign DOUT = PAD;

endmodule

// File: rtl/ram_bus_controller.sv
// Request sequencer for the bidirectional-bus RAM: one write per 2 cycles,
// one read per 3 cycles (read, turnaround, idle).
module ram_bus_controller
  import ram_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     REQ_VALID,
  output logic                     REQ_READY,
  input  logic                     REQ_WRITE,
  input  logic [$clog2(DEPTH)-1:0] REQ_ADDR,
  input  logic [WIDTH-1:0]         REQ_WDATA,
  output logic                     RD_VALID,
  output logic [WIDTH-1:0]         RD_DATA,
  output logic                     CS_,
  output logic                     WS,
  output logic                     OE,
  output logic [$clog2(DEPTH)-1:0] ADDR,
  inout  wire  [WIDTH-1:0]         DATA
);

  ctrl_state_t      state, nxt;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] bus_in;
  logic             accept;
  logic             drive;

  // Only IDLE takes requests; reset forces ready low regardless of state.
  assign REQ_READY = (state == IDLE) && !RST;
  assign accept    = REQ_VALID && (state == IDLE);
  // Drive strictly in the WRITE cycle, so drive and OE can never overlap.
  assign drive     = (state == WRITE);

  bus_tristate #(.WIDTH(WIDTH)) u_tri (
    .EN   (drive),
    .DIN  (wdata_q),
    .DOUT (bus_in),
    .PAD  (DATA)
  );

  // Next-state: every non-idle state lasts exactly one cycle.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = REQ_WRITE ? WRITE : READ;
      WRITE:   nxt = IDLE;
      READ:    nxt = TURN;
      TURN:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // State plus registered RAM strobes, decoded from the state being entered
  // so that they line up with the state they belong to.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      CS_      <= 1'b1;
      WS       <= 1'b0;
      OE       <= 1'b0;
      RD_VALID <= 1'b0;
      ADDR     <= '0;
      wdata_q  <= '0;
      RD_DATA  <= '0;
    end else begin
      state    <= nxt;
      CS_      <= !((nxt == WRITE) || (nxt == READ));
      WS       <= (nxt == WRITE);
      OE       <= (nxt == READ);
      RD_VALID <= (nxt == TURN);
      if (accept) begin
        ADDR    <= REQ_ADDR;
        wdata_q <= REQ_WDATA;
      end
      // RAM drives DATA combinationally during READ; capture at its closing edge.
      if (state == READ) RD_DATA <= bus_in;
    end
  end

endmodule

// File: tb/tb_ram_bus_controller.sv
// Directed bench with a transaction-level timeline model and a small RAM model.
module tb_ram_bus_controller;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       REQ_VALID = 1'b0;
  logic       REQ_READY;
  logic       REQ_WRITE = 1'b0;
  logic [4:0] REQ_ADDR = '0;
  logic [7:0] REQ_WDATA = '0;
  logic       RD_VALID;
  logic [7:0] RD_DATA;
  logic       CS_, WS, OE;
  logic [4:0] ADDR;
  wire  [7:0] DATA;

  ram_bus_controller #(.WIDTH(8), .DEPTH(32)) dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RD_VALID(RD_VALID), .RD_DATA(RD_DATA), .CS_(CS_), .WS(WS), .OE(OE),
    .ADDR(ADDR), .DATA(DATA)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM device on the bus: async read while selected+OE, write at edge with WS.
  logic [7:0] ram [32];
  initial for (int i = 0; i < 32; i++) ram[i] = 8'h00;
  assign DATA = (OE && !CS_) ? ram[ADDR] : 8'bz;
  always @(posedge CLK) if (!CS_ && WS) ram[ADDR] <= DATA;

  // Probe driver: only on when the controller must have released the bus.
  logic probe_en;
  assign DATA = probe_en ? 8'h5A : 8'bz;

  // Timeline model: each accepted request schedules the cycles it occupies.
  typedef struct {
    bit         wr;
    bit         rd;
    bit         turn;
    logic [4:0] a;
    logic [7:0] d;
  } slot_t;

  slot_t      q[$];
  logic [7:0] mm [32];
  logic [4:0] m_addr = '0;
  logic [7:0] m_rdata = '0;
  bit         m_idle;
  bit e_cs = 1, e_ws = 0, e_oe = 0, e_rdv = 0, e_wr = 0;
  logic [7:0] e_wd = '0;
  initial for (int i = 0; i < 32; i++) mm[i] = 8'h00;

  function automatic void upd_exp();
    if (q.size() == 0) begin
      e_cs = 1; e_ws = 0; e_oe = 0; e_rdv = 0; e_wr = 0;
    end else begin
      e_cs  = !(q[0].wr || q[0].rd);
      e_ws  = q[0].wr;
      e_oe  = q[0].rd;
      e_rdv = q[0].turn;
      e_wr  = q[0].wr;
      e_wd  = q[0].d;
    end
  endfunction

  always_comb probe_en = !e_wr && !e_oe;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      q.delete();
      m_addr  = '0;
      m_rdata = '0;
    end else begin
      m_idle = (q.size() == 0);
      if (!m_idle) begin
        if (q[0].wr) mm[q[0].a] = q[0].d;
        if (q[0].rd) m_rdata = mm[q[0].a];
        void'(q.pop_front());
      end
      if (m_idle && REQ_VALID) begin
        m_addr = REQ_ADDR;
        if (REQ_WRITE) q.push_back('{1'b1, 1'b0, 1'b0, REQ_ADDR, REQ_WDATA});
        else begin
          q.push_back('{1'b0, 1'b1, 1'b0, REQ_ADDR, 8'h00});
          q.push_back('{1'b0, 1'b0, 1'b1, REQ_ADDR, 8'h00});
        end
      end
    end
    upd_exp();
  end

  task automatic check_all(input string tag);
    chk({tag, ".ready"}, REQ_READY, !RST && (q.size() == 0));
    chk({tag, ".cs_"},   CS_,  e_cs);
    chk({tag, ".ws"},    WS,   e_ws);
    chk({tag, ".oe"},    OE,   e_oe);
    chk({tag, ".addr"},  ADDR, m_addr);
    chk({tag, ".rdv"},   RD_VALID, e_rdv);
    chk({tag, ".rdata"}, RD_DATA, m_rdata);
    if (e_wr)     chk({tag, ".data_wr"},  DATA, e_wd);
    if (probe_en) chk({tag, ".data_rel"}, DATA, 8'h5A);
  endtask

  // Per-cycle comparison against the model, plus event counters.
  int acc_cnt = 0, ws_cnt = 0, rdv_cnt = 0;
  always @(negedge CLK) begin
    check_all("cyc");
    if (WS) ws_cnt++;
    if (RD_VALID) rdv_cnt++;
  end
  always @(posedge CLK) if (!RST && REQ_VALID && REQ_READY) acc_cnt++;

  // Present a request, hold it until accepted; waits = cycles spent not ready.
  task automatic req(input bit w, input logic [4:0] a, input logic [7:0] d, output int waits);
    waits = 0;
    REQ_VALID = 1; REQ_WRITE = w; REQ_ADDR = a; REQ_WDATA = d;
    forever begin
      @(negedge CLK);
      if (REQ_READY) break;
      waits++;
      if (waits > 20) begin chk("req_timeout", 1, 0); break; end
    end
    @(posedge CLK); #1;
    REQ_VALID = 0;
  endtask

  // Wait for RD_VALID; n = negedges observed up to and including the pulse.
  task automatic wait_rd(output int n, output logic [7:0] data);
    n = 0; data = 'x;
    forever begin
      @(negedge CLK);
      n++;
      if (RD_VALID) begin data = RD_DATA; break; end
      if (n > 20) begin chk("rd_timeout", 1, 0); break; end
    end
  endtask

  int w, n, k;
  bit rdy;
  logic [7:0] rd;

  initial begin
    repeat (2) @(negedge CLK);
    RST = 0;
    @(posedge CLK); #1;

    // 1: reset mid-WRITE with a request held valid
    req(1, 5'd7, 8'h77, w);
    REQ_VALID = 1;
    #2 RST = 1;
    #1;
    check_all("rst");
    chk("rst.cs_lit", CS_, 1);
    chk("rst.ws_lit", WS, 0);
    chk("rst.ready_lit", REQ_READY, 0);
    @(negedge CLK);
    RST = 0; REQ_VALID = 0;
    @(negedge CLK);
    chk("rst.ready_after", REQ_READY, 1);

    // 2: write 5<=A5 then read 5
    @(posedge CLK); #1;
    req(1, 5'd5, 8'hA5, w);
    req(0, 5'd5, 8'h00, w);
    wait_rd(n, rd);
    chk("t2.rd_lat", n, 2);
    chk("t2.rd_lit", rd, 8'hA5);

    // 3: read 3 then write 3C held valid -> waits out READ and TURN
    req(0, 5'd3, 8'h00, w);
    req(1, 5'd3, 8'h3C, w);
    chk("t3.wr_waits", w, 2);
    req(0, 5'd3, 8'h00, w);
    wait_rd(n, rd);
    chk("t3.rd_lit", rd, 8'h3C);

    // 4: held valid for 6 cycles, writes to addresses 0..2
    @(posedge CLK); #1;
    acc_cnt = 0; ws_cnt = 0; k = 0;
    REQ_VALID = 1; REQ_WRITE = 1; REQ_ADDR = 5'd0; REQ_WDATA = 8'h10;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK); rdy = REQ_READY;
      @(posedge CLK); #1;
      if (rdy) begin k++; REQ_ADDR = 5'(k); REQ_WDATA = 8'h10 + 8'(k); end
    end
    REQ_VALID = 0;
    @(negedge CLK);
    chk("t4.accepts", acc_cnt, 3);
    chk("t4.ws_pulses", ws_cnt, 3);

    // 5: boundary addresses
    req(1, 5'd0, 8'h01, w);
    req(1, 5'd31, 8'hFF, w);
    rdv_cnt = 0;
    req(0, 5'd0, 8'h00, w);
    wait_rd(n, rd);
    chk("t5.rd0", rd, 8'h01);
    req(0, 5'd31, 8'h00, w);
    wait_rd(n, rd);
    chk("t5.rd31", rd, 8'hFF);
    @(negedge CLK);
    chk("t5.pulses", rdv_cnt, 2);

    // 6: reset in the READ cycle
    req(0, 5'd5, 8'h00, w);
    rdv_cnt = 0;
    #2 RST = 1;
    #1;
    chk("t6.oe", OE, 0);
    chk("t6.rdata", RD_DATA, 8'h00);
    chk("t6.rdv", RD_VALID, 0);
    @(negedge CLK);
    RST = 0;
    repeat (3) @(negedge CLK);
    chk("t6.no_pulse", rdv_cnt, 0);
    @(posedge CLK); #1;
    req(0, 5'd5, 8'h00, w);
    wait_rd(n, rd);
    chk("t6.rd_after", rd, 8'hA5);

    repeat (2) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
